// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receive front end.
// The optional parity check is selected with PS2_RX_PARITY_CHECK_EN.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
  localparam int unsigned PS2_DATA_BITS  = 8;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, consecutive-sample glitch filter and falling-edge strobe
// for an asynchronous open-collector PS/2 line (idle level 1).
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            meta_q, sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q, fall_d;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    fall_d = 1'b0;
    if (sync_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_d = sync_q;
      cnt_d  = '0;
      fall_d = filt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserialises device frames, folds 0xE0/0xF0 prefixes into
// flags and hands one scan code per key event downstream. Macro: PS2_RX_PARITY_CHECK_EN.
module ps2_kbd_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       scan_read,
  output logic       scan_ready,
  output logic [7:0] scan_code,
  output logic       scan_released,
  output logic       scan_extended,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned TmoBits = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TmoW    = (TmoBits > 16) ? TmoBits : 16;

  logic fall_stb;
  logic data_meta_q, data_sync_q;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            rel_pend_q, rel_pend_d;
  logic            ext_pend_q, ext_pend_d;

  logic            scan_ready_q, scan_ready_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            scan_released_q, scan_released_d;
  logic            scan_extended_q, scan_extended_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            deliver;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .line_i(ps2_clk_i),
    .fall_o(fall_stb)
  );

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    tmo_cnt_d       = tmo_cnt_q;
    rel_pend_d      = rel_pend_q;
    ext_pend_d      = ext_pend_q;
    scan_ready_d    = scan_ready_q & ~scan_read;
    scan_code_d     = scan_code_q;
    scan_released_d = scan_released_q;
    scan_extended_d = scan_extended_q;
    frame_err_d     = 1'b0;
    overrun_d       = 1'b0;
    deliver         = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d           = par_q;
    parity_err_d    = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        tmo_cnt_d = '0;
        bit_cnt_d = '0;
        if (fall_stb) begin
          if (!data_sync_q) begin
            state_d = StData;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall_stb) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall_stb) begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d = data_sync_q;
`endif
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall_stb) begin
          state_d = StIdle;
          if (!data_sync_q) begin
            // Bad stop bit: drop the byte but keep any prefix already seen.
            frame_err_d = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
          end else if (!ps2_parity_ok(shift_q, par_q)) begin
            parity_err_d = 1'b1;
            rel_pend_d   = 1'b0;
            ext_pend_d   = 1'b0;
`endif
          end else if (shift_q == PS2_BREAK_CODE) begin
            rel_pend_d = 1'b1;
          end else if (shift_q == PS2_EXT_CODE) begin
            ext_pend_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Mid-frame watchdog; it only fires in cycles without a strobe.
    if (state_q != StIdle) begin
      if (fall_stb) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = StIdle;
        tmo_cnt_d   = '0;
        shift_d     = '0;
        rel_pend_d  = 1'b0;
        ext_pend_d  = 1'b0;
        frame_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end

    if (deliver) begin
      if (scan_ready_q && !scan_read) begin
        overrun_d = 1'b1;
      end else begin
        scan_ready_d    = 1'b1;
        scan_code_d     = shift_q;
        scan_released_d = rel_pend_q;
        scan_extended_d = ext_pend_q;
      end
      rel_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta_q     <= 1'b1;
      data_sync_q     <= 1'b1;
      state_q         <= StIdle;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      tmo_cnt_q       <= '0;
      rel_pend_q      <= 1'b0;
      ext_pend_q      <= 1'b0;
      scan_ready_q    <= 1'b0;
      scan_code_q     <= '0;
      scan_released_q <= 1'b0;
      scan_extended_q <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_q       <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q           <= 1'b0;
      parity_err_q    <= 1'b0;
`endif
    end else begin
      data_meta_q     <= ps2_data_i;
      data_sync_q     <= data_meta_q;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      tmo_cnt_q       <= tmo_cnt_d;
      rel_pend_q      <= rel_pend_d;
      ext_pend_q      <= ext_pend_d;
      scan_ready_q    <= scan_ready_d;
      scan_code_q     <= scan_code_d;
      scan_released_q <= scan_released_d;
      scan_extended_q <= scan_extended_d;
      frame_err_q     <= frame_err_d;
      overrun_q       <= overrun_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q           <= par_d;
      parity_err_q    <= parity_err_d;
`endif
    end
  end

  assign scan_ready    = scan_ready_q;
  assign scan_code     = scan_code_q;
  assign scan_released = scan_released_q;
  assign scan_extended = scan_extended_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_err    = parity_err_q;
`else
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx; PS/2 frames are bit-banged
// with a slow device clock and outputs are sampled on the falling clk edge.
module tb_ps2_kbd_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       scan_read;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       scan_released;
  logic       scan_extended;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  ps2_kbd_rx #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .scan_read    (scan_read),
    .scan_ready   (scan_ready),
    .scan_code    (scan_code),
    .scan_released(scan_released),
    .scan_extended(scan_extended),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_dlv = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_rdy_fall = 0;
  logic rdy_prev = 1'b0;

  // Event counters: ready rising/falling edges and cycles each pulse is high.
  always @(negedge clk) begin
    if (scan_ready && !rdy_prev) n_dlv++;
    if (!scan_ready && rdy_prev) n_rdy_fall++;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (overrun) n_ovr++;
    rdy_prev <= scan_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One device bit; with ack_here, scan_read is pulsed in the cycle the stop
  // bit is taken (2 sync + FILT filter samples after the raw falling edge).
  task automatic ps2_bit(input logic b, input bit ack_here);
    @(negedge clk) ps2_data_i = b;
    repeat (HALF) @(negedge clk);
    ps2_clk_i = 1'b0;
    if (ack_here) begin
      repeat (FILT + 2) @(posedge clk);
      @(negedge clk) scan_read = 1'b1;
      @(negedge clk) scan_read = 1'b0;
      repeat (HALF - FILT - 4) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit ack_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(1'b1, ack_stop);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk) scan_read = 1'b1;
    @(negedge clk) scan_read = 1'b0;
    @(negedge clk);
  endtask

  int dlv0, ferr0, perr0, ovr0, fall0;

  initial begin
    rst        = 1'b1;
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    scan_read  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_ready", 32'(scan_ready), 32'd0);
    chk("rst_code", 32'(scan_code), 32'h00);
    chk("rst_flags", 32'({scan_released, scan_extended}), 32'd0);
    chk("rst_pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Plain make code
    dlv0 = n_dlv;
    send_byte(8'h1C, 1'b0, 1'b0);
    chk("mk_ready", 32'(scan_ready), 32'd1);
    chk("mk_code", 32'(scan_code), 32'h1C);
    chk("mk_flags", 32'({scan_released, scan_extended}), 32'd0);
    chk("mk_count", 32'(n_dlv - dlv0), 32'd1);
    ack();
    chk("mk_ack", 32'(scan_ready), 32'd0);

    // Break code
    dlv0 = n_dlv;
    send_byte(8'hF0, 1'b0, 1'b0);
    chk("brk_prefix_silent", 32'(scan_ready), 32'd0);
    send_byte(8'h1C, 1'b0, 1'b0);
    chk("brk_code", 32'(scan_code), 32'h1C);
    chk("brk_flags", 32'({scan_released, scan_extended}), 32'b10);
    chk("brk_count", 32'(n_dlv - dlv0), 32'd1);
    ack();

    // Extended break code
    dlv0 = n_dlv;
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    chk("ext_code", 32'(scan_code), 32'h74);
    chk("ext_flags", 32'({scan_released, scan_extended}), 32'b11);
    chk("ext_count", 32'(n_dlv - dlv0), 32'd1);
    ack();

    // Even parity
    dlv0  = n_dlv;
    perr0 = n_perr;
    send_byte(8'h1C, 1'b1, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    chk("par_err_pulse", 32'(n_perr - perr0), 32'd1);
    chk("par_no_ready", 32'(scan_ready), 32'd0);
    chk("par_no_dlv", 32'(n_dlv - dlv0), 32'd0);
`else
    chk("par_ign_code", 32'(scan_code), 32'h1C);
    chk("par_ign_dlv", 32'(n_dlv - dlv0), 32'd1);
    chk("par_ign_noerr", 32'(n_perr - perr0), 32'd0);
    ack();
`endif

    // Timeout after a break prefix and a partial frame
    ferr0 = n_ferr;
    send_byte(8'hF0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    chk("tmo_ferr", 32'(n_ferr - ferr0), 32'd1);
    chk("tmo_no_ready", 32'(scan_ready), 32'd0);
    send_byte(8'h2B, 1'b0, 1'b0);
    chk("tmo_next_code", 32'(scan_code), 32'h2B);
    chk("tmo_next_flags", 32'({scan_ready, scan_released, scan_extended}), 32'b100);
    ack();

    // Overrun, then read coincident with delivery
    ovr0 = n_ovr;
    send_byte(8'h15, 1'b0, 1'b0);
    send_byte(8'h1D, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(n_ovr - ovr0), 32'd1);
    chk("ovr_code_kept", 32'(scan_code), 32'h15);
    chk("ovr_ready", 32'(scan_ready), 32'd1);
    ovr0  = n_ovr;
    fall0 = n_rdy_fall;
    send_byte(8'h24, 1'b0, 1'b1);
    chk("sim_code", 32'(scan_code), 32'h24);
    chk("sim_ready_held", 32'(scan_ready), 32'd1);
    chk("sim_no_drop", 32'(n_rdy_fall - fall0), 32'd0);
    chk("sim_no_ovr", 32'(n_ovr - ovr0), 32'd0);
    ack();

    // Short glitch on the clock line while idle
    ferr0 = n_ferr;
    dlv0  = n_dlv;
    @(negedge clk) ps2_clk_i = 1'b0;
    repeat (FILT - 2) @(negedge clk);
    ps2_clk_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_ferr", 32'(n_ferr - ferr0), 32'd0);
    chk("glitch_no_dlv", 32'(n_dlv - dlv0), 32'd0);

    // Reset in the middle of a frame with a code still pending
    send_byte(8'h33, 1'b0, 1'b0);
    chk("pre_rst_ready", 32'(scan_ready), 32'd1);
    ferr0 = n_ferr;
    perr0 = n_perr;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs",
        32'({scan_ready, scan_code, scan_released, scan_extended, frame_err, parity_err, overrun}),
        32'd0);
    repeat (50) @(negedge clk);
    chk("mid_rst_silent", 32'(n_ferr - ferr0 + n_perr - perr0), 32'd0);
    send_byte(8'h4D, 1'b0, 1'b0);
    chk("post_rst_code", 32'(scan_code), 32'h4D);
    chk("post_rst_flags", 32'({scan_ready, scan_released, scan_extended}), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
